// File: rtl/mvau_weight_loader_if.sv
// Weight stream in and PE weight-memory write port out, bundled for the loader.
interface mvau_weight_loader_if #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_ADDR_BW = 4
) ();
  logic [SIMD*TW-1:0]      s_axis_wdata;
  logic                    s_axis_wvalid;
  logic                    s_axis_wready;
  logic [PE-1:0]           wmem_we;
  logic [WMEM_ADDR_BW-1:0] wmem_waddr;
  logic [SIMD*TW-1:0]      wmem_wdata;

  // master: host/DMA stream source that also observes the memory write port
  modport master (
    output s_axis_wdata, s_axis_wvalid,
    input  s_axis_wready, wmem_we, wmem_waddr, wmem_wdata
  );

  // slave: the loader, consuming the stream and driving the memory writes
  modport slave (
    input  s_axis_wdata, s_axis_wvalid,
    output s_axis_wready, wmem_we, wmem_waddr, wmem_wdata
  );
endinterface

// File: rtl/mvau_weight_loader.sv
// Streams weight word k into PE memory (k mod PE) at address (k div PE); writes land 1 cycle after handshake.
// wready is high only in LOAD, so upstream stalls outside a load; load_done pulses 1 cycle after the last write.
module mvau_weight_loader #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 load_start,
  output logic                 load_busy,
  output logic                 load_done,
  mvau_weight_loader_if.slave  bus
);

  localparam int W     = SIMD * TW;
  localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state;
  logic [PE_BW-1:0]        pe_cnt;
  logic [WMEM_ADDR_BW-1:0] addr_cnt;
  logic [PE-1:0]           we_q;
  logic [WMEM_ADDR_BW-1:0] waddr_q;
  logic [W-1:0]            wdata_q;
  logic                    done_q;
  logic [PE-1:0]           we_sel;
  logic                    hs;
  logic                    pe_last;
  logic                    addr_last;

  assign bus.s_axis_wready = (state == LOAD);
  assign hs                = bus.s_axis_wvalid && (state == LOAD);
  assign pe_last           = (pe_cnt == PE_BW'(PE - 1));
  assign addr_last         = (addr_cnt == WMEM_ADDR_BW'(WMEM_DEPTH - 1));

  always_comb begin
    we_sel = '0;
    for (int p = 0; p < PE; p++) begin
      we_sel[p] = (pe_cnt == PE_BW'(p));
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      pe_cnt   <= '0;
      addr_cnt <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      we_q   <= '0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            pe_cnt   <= '0;
            addr_cnt <= '0;
          end
        end
        LOAD: begin
          if (hs) begin
            we_q    <= we_sel;
            waddr_q <= addr_cnt;
            wdata_q <= bus.s_axis_wdata;
            // explicit wrap so non-power-of-two PE / depth work
            if (pe_last) begin
              pe_cnt <= '0;
              if (addr_last) begin
                state <= DONE;
              end else begin
                addr_cnt <= addr_cnt + WMEM_ADDR_BW'(1);
              end
            end else begin
              pe_cnt <= pe_cnt + PE_BW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wmem_we    = we_q;
  assign bus.wmem_waddr = waddr_q;
  assign bus.wmem_wdata = wdata_q;
  assign load_busy      = (state != IDLE);
  assign load_done      = done_q;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader: PE=2/DEPTH=4 instance plus a PE=3/DEPTH=3 instance.
module tb_mvau_weight_loader;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic aresetn;
  logic ls_a, busy_a, done_a;
  logic ls_b, busy_b, done_b;
  int   checks = 0;
  int   errors = 0;

  mvau_weight_loader_if #(.SIMD(4), .TW(2), .PE(2), .WMEM_ADDR_BW(4)) ifa ();
  mvau_weight_loader_if #(.SIMD(4), .TW(2), .PE(3), .WMEM_ADDR_BW(4)) ifb ();

  mvau_weight_loader #(.SIMD(4), .TW(2), .PE(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .load_start(ls_a),
    .load_busy(busy_a), .load_done(done_a), .bus(ifa)
  );

  mvau_weight_loader #(.SIMD(4), .TW(2), .PE(3), .WMEM_DEPTH(3), .WMEM_ADDR_BW(4)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .load_start(ls_b),
    .load_busy(busy_b), .load_done(done_b), .bus(ifb)
  );

  logic [1:0] exp_we_a   [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [3:0] exp_addr_a [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
  logic [2:0] exp_we_b   [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [3:0] exp_addr_b [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};

  task automatic test_reset();
    aresetn = 1'b0; ls_a = 1'b0; ls_b = 1'b0;
    ifa.s_axis_wvalid = 1'b0; ifa.s_axis_wdata = '0;
    ifb.s_axis_wvalid = 1'b0; ifb.s_axis_wdata = '0;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (ifa.s_axis_wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b want 0", ifa.s_axis_wready); end
    checks++; if (ifa.wmem_we !== 2'b00) begin errors++; $display("FAIL reset_we got %b want 00", ifa.wmem_we); end
    checks++; if (ifa.wmem_waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", ifa.wmem_waddr); end
    checks++; if (ifa.wmem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", ifa.wmem_wdata); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (ifb.wmem_we !== 3'b000 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b we=%b busy=%b want 000/0", ifb.wmem_we, busy_b); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic_load();
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    checks++; if (ifa.s_axis_wready !== 1'b1) begin errors++; $display("FAIL basic_start_wready got %b want 1", ifa.s_axis_wready); end
    ifa.s_axis_wvalid = 1'b1; ifa.s_axis_wdata = 8'h10;
    for (int k = 0; k < 8; k++) begin
      @(posedge aclk); #1;
      checks++; if (ifa.wmem_we !== exp_we_a[k]) begin errors++; $display("FAIL basic_we[%0d] got %b want %b", k, ifa.wmem_we, exp_we_a[k]); end
      checks++; if (ifa.wmem_waddr !== exp_addr_a[k]) begin errors++; $display("FAIL basic_addr[%0d] got %0d want %0d", k, ifa.wmem_waddr, exp_addr_a[k]); end
      checks++; if (ifa.wmem_wdata !== 8'h10 + 8'(k)) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", k, ifa.wmem_wdata, 8'h10 + 8'(k)); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_early_done[%0d] got %b want 0", k, done_a); end
      ifa.s_axis_wdata = 8'h11 + 8'(k);
    end
    ifa.s_axis_wvalid = 1'b0;
    checks++; if (ifa.s_axis_wready !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL basic_done_state wready=%b busy=%b want 0/1", ifa.s_axis_wready, busy_a); end
    @(posedge aclk); #1;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got %b want 1", done_a); end
    checks++; if (busy_a !== 1'b0 || ifa.wmem_we !== 2'b00 || ifa.s_axis_wready !== 1'b0) begin errors++; $display("FAIL basic_after busy=%b we=%b wready=%b want 0/00/0", busy_a, ifa.wmem_we, ifa.s_axis_wready); end
    @(posedge aclk); #1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done_single got %b want 0", done_a); end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat = 16'b0110_1011_0011_0101;
    int k = 0;
    int c = 0;
    logic hs;
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    while (k < 8 && c < 48) begin
      hs = pat[c % 16];
      ifa.s_axis_wvalid = hs;
      ifa.s_axis_wdata  = hs ? 8'h20 + 8'(k) : 8'hFF;
      @(posedge aclk); #1;
      c++;
      if (hs) begin
        checks++; if (ifa.wmem_we !== exp_we_a[k] || ifa.wmem_waddr !== exp_addr_a[k] || ifa.wmem_wdata !== 8'h20 + 8'(k)) begin
          errors++; $display("FAIL bp_write[%0d] got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                             k, ifa.wmem_we, ifa.wmem_waddr, ifa.wmem_wdata, exp_we_a[k], exp_addr_a[k], 8'h20 + 8'(k));
        end
        k++;
      end else begin
        checks++; if (ifa.wmem_we !== 2'b00) begin errors++; $display("FAIL bp_gap_we cycle %0d got %b want 00", c, ifa.wmem_we); end
      end
    end
    ifa.s_axis_wvalid = 1'b0;
    checks++; if (k !== 8) begin errors++; $display("FAIL bp_count got %0d writes want 8", k); end
    @(posedge aclk); #1;
    checks++; if (done_a !== 1'b1 || ifa.wmem_we !== 2'b00) begin errors++; $display("FAIL bp_done done=%b we=%b want 1/00", done_a, ifa.wmem_we); end
  endtask

  task automatic test_start_while_busy();
    ifa.s_axis_wvalid = 1'b1; ifa.s_axis_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      checks++; if (ifa.s_axis_wready !== 1'b0 || ifa.wmem_we !== 2'b00 || busy_a !== 1'b0) begin
        errors++; $display("FAIL idle_wvalid[%0d] wready=%b we=%b busy=%b want 0/00/0", i, ifa.s_axis_wready, ifa.wmem_we, busy_a);
      end
    end
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    checks++; if (ifa.wmem_we !== 2'b00 || ifa.s_axis_wready !== 1'b1) begin errors++; $display("FAIL swb_start we=%b wready=%b want 00/1", ifa.wmem_we, ifa.s_axis_wready); end
    ifa.s_axis_wdata = 8'h30;
    for (int k = 0; k < 8; k++) begin
      @(posedge aclk); #1;
      checks++; if (ifa.wmem_we !== exp_we_a[k] || ifa.wmem_waddr !== exp_addr_a[k] || ifa.wmem_wdata !== 8'h30 + 8'(k)) begin
        errors++; $display("FAIL swb_write[%0d] got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                           k, ifa.wmem_we, ifa.wmem_waddr, ifa.wmem_wdata, exp_we_a[k], exp_addr_a[k], 8'h30 + 8'(k));
      end
      ifa.s_axis_wdata = 8'h31 + 8'(k);
      ls_a = (k == 2);
    end
    ifa.s_axis_wvalid = 1'b0;
    @(posedge aclk); #1;
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL swb_done done=%b busy=%b want 1/0", done_a, busy_a); end
  endtask

  task automatic test_reset_mid_load();
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    ifa.s_axis_wvalid = 1'b1; ifa.s_axis_wdata = 8'h40;
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      checks++; if (ifa.wmem_we !== exp_we_a[k] || ifa.wmem_waddr !== exp_addr_a[k]) begin
        errors++; $display("FAIL rml_write[%0d] we=%b addr=%0d want %b/%0d", k, ifa.wmem_we, ifa.wmem_waddr, exp_we_a[k], exp_addr_a[k]);
      end
      ifa.s_axis_wdata = 8'h41 + 8'(k);
    end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    checks++; if (ifa.wmem_we !== 2'b00 || ifa.wmem_waddr !== 4'd0 || ifa.wmem_wdata !== 8'h00) begin
      errors++; $display("FAIL rml_outputs we=%b addr=%0d data=%h want 00/0/00", ifa.wmem_we, ifa.wmem_waddr, ifa.wmem_wdata);
    end
    checks++; if (ifa.s_axis_wready !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL rml_state wready=%b busy=%b done=%b want 0/0/0", ifa.s_axis_wready, busy_a, done_a);
    end
    aresetn = 1'b1; ifa.s_axis_wvalid = 1'b0;
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    ifa.s_axis_wvalid = 1'b1; ifa.s_axis_wdata = 8'h4A;
    @(posedge aclk); #1;
    checks++; if (ifa.wmem_we !== 2'b01 || ifa.wmem_waddr !== 4'd0 || ifa.wmem_wdata !== 8'h4A) begin
      errors++; $display("FAIL rml_restart we=%b addr=%0d data=%h want 01/0/4a", ifa.wmem_we, ifa.wmem_waddr, ifa.wmem_wdata);
    end
    ifa.s_axis_wvalid = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_non_pow2();
    ls_b = 1'b1;
    @(posedge aclk); #1;
    ls_b = 1'b0;
    ifb.s_axis_wvalid = 1'b1; ifb.s_axis_wdata = 8'h50;
    for (int k = 0; k < 9; k++) begin
      @(posedge aclk); #1;
      checks++; if (ifb.wmem_we !== exp_we_b[k] || ifb.wmem_waddr !== exp_addr_b[k] || ifb.wmem_wdata !== 8'h50 + 8'(k)) begin
        errors++; $display("FAIL np2_write[%0d] got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                           k, ifb.wmem_we, ifb.wmem_waddr, ifb.wmem_wdata, exp_we_b[k], exp_addr_b[k], 8'h50 + 8'(k));
      end
      checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL np2_early_done[%0d] got %b want 0", k, done_b); end
      ifb.s_axis_wdata = 8'h51 + 8'(k);
    end
    ifb.s_axis_wvalid = 1'b0;
    @(posedge aclk); #1;
    checks++; if (done_b !== 1'b1 || ifb.wmem_we !== 3'b000) begin errors++; $display("FAIL np2_done done=%b we=%b want 1/000", done_b, ifb.wmem_we); end
  endtask

  task automatic test_back_to_back();
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    ifa.s_axis_wvalid = 1'b1; ifa.s_axis_wdata = 8'h60;
    for (int k = 0; k < 8; k++) begin
      @(posedge aclk); #1;
      ifa.s_axis_wdata = 8'h61 + 8'(k);
    end
    ifa.s_axis_wvalid = 1'b0;
    @(posedge aclk); #1;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done_a); end
    ls_a = 1'b1;
    @(posedge aclk); #1;
    ls_a = 1'b0;
    checks++; if (ifa.s_axis_wready !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_restart wready=%b done=%b busy=%b want 1/0/1", ifa.s_axis_wready, done_a, busy_a);
    end
    ifa.s_axis_wvalid = 1'b1; ifa.s_axis_wdata = 8'h70;
    for (int k = 0; k < 8; k++) begin
      @(posedge aclk); #1;
      checks++; if (ifa.wmem_we !== exp_we_a[k] || ifa.wmem_waddr !== exp_addr_a[k] || ifa.wmem_wdata !== 8'h70 + 8'(k)) begin
        errors++; $display("FAIL b2b_write[%0d] got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                           k, ifa.wmem_we, ifa.wmem_waddr, ifa.wmem_wdata, exp_we_a[k], exp_addr_a[k], 8'h70 + 8'(k));
      end
      ifa.s_axis_wdata = 8'h71 + 8'(k);
    end
    ifa.s_axis_wvalid = 1'b0;
    @(posedge aclk); #1;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", done_a); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_load();
    test_non_pow2();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
